// File: rtl/clk_rst_seq_pkg.sv
// Shared definitions for the clock-enable / reset sequencer.
package clk_rst_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STAGING   = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Bits needed to hold 0..n-1; never less than 1.
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/clk_rst_seq_ce_div.sv
// One channel of programmable clock-enable division.
module ce_div
  import clk_rst_pkg::*;
#(
  parameter int unsigned DIVW      = 8,
  parameter int unsigned DIV_RESET = 1
) (
  input  logic            clock_50,
  input  logic            reset_n,
  input  logic            en,
  input  logic            load,
  input  logic [DIVW-1:0] div,
  output logic            ce
);

  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] cnt;
  logic            ce_q;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIVW'(DIV_RESET);
      cnt   <= '0;
      ce_q  <= 1'b0;
    end else begin
      if (load) div_q <= div;
      if (load || !en) begin
        cnt  <= '0;
        ce_q <= 1'b0;
      end else if (div_q <= DIVW'(1)) begin
        cnt  <= '0;
        ce_q <= 1'b1;
      end else if (cnt == div_q - DIVW'(1)) begin
        cnt  <= '0;
        ce_q <= 1'b1;
      end else begin
        cnt  <= cnt + DIVW'(1);
        ce_q <= 1'b0;
      end
    end
  end

  // Gate with the channel reset so ce drops on the same edge the reset asserts.
  assign ce = ce_q & en;

endmodule

// File: rtl/clk_rst_seq.sv
// Lock filter, staged per-domain reset release and clock-enable generation.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIVW        = 8,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned DIV_RESET   = 1
) (
  input  logic                 clock_50,
  input  logic                 reset_n,
  input  logic                 pll_locked,
  input  logic                 div_load,
  input  logic [NCH*DIVW-1:0]  div_in,
  output logic [NCH-1:0]       ce,
  output logic [NCH-1:0]       rst_n_out,
  output logic                 ready,
  output logic [CNT_W-1:0]     lock_lost_cnt,
  output logic [1:0]           state_o
);

  localparam int unsigned SW = clog2_w(LOCK_STABLE);
  localparam int unsigned GW = clog2_w(STAGE_GAP);
  localparam int unsigned KW = clog2_w(NCH + 1);

  logic [1:0]    sync_q;
  logic          lock_s;
  state_t        state;
  logic [SW-1:0] stable_cnt;
  logic [GW-1:0] gap_cnt;
  logic [KW-1:0] stage_k;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], pll_locked};
  end

  assign lock_s = sync_q[1];

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_WAIT_LOCK;
      stable_cnt    <= '0;
      gap_cnt       <= '0;
      stage_k       <= '0;
      rst_n_out     <= '0;
      ready         <= 1'b0;
      lock_lost_cnt <= '0;
    end else if (!lock_s) begin
      if ((state == ST_STAGING || state == ST_RUN) && lock_lost_cnt != '1)
        lock_lost_cnt <= lock_lost_cnt + CNT_W'(1);
      state      <= ST_WAIT_LOCK;
      stable_cnt <= '0;
      gap_cnt    <= '0;
      stage_k    <= '0;
      rst_n_out  <= '0;
      ready      <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          if (stable_cnt == SW'(LOCK_STABLE - 1)) begin
            state      <= ST_STAGING;
            stable_cnt <= '0;
            gap_cnt    <= '0;
            stage_k    <= '0;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end
        ST_STAGING: begin
          if (stage_k == KW'(NCH)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else if (gap_cnt == GW'(STAGE_GAP - 1)) begin
            gap_cnt <= '0;
            stage_k <= stage_k + KW'(1);
            for (int unsigned i = 0; i < NCH; i++)
              if (KW'(i) == stage_k) rst_n_out[i] <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_RUN: ready <= 1'b1;
        default: begin
          state     <= ST_WAIT_LOCK;
          rst_n_out <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ce_div #(
      .DIVW      (DIVW),
      .DIV_RESET (DIV_RESET)
    ) u_ce_div (
      .clock_50 (clock_50),
      .reset_n  (reset_n),
      .en       (rst_n_out[i]),
      .load     (div_load),
      .div      (div_in[i*DIVW +: DIVW]),
      .ce       (ce[i])
    );
  end

endmodule
